// File: rtl/uart_mmio_tx.sv
// MMIO-fed UART transmitter: bytes written by the memory stage are queued in a
// small FIFO and shifted out on tx as 8N1 frames, LSB first.
`timescale 1ns/1ps
module uart_mmio_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        Rst,
  input  logic                        mmio_wea,
  input  logic [31:0]                 mmio_dat,
  output logic                        mmio_read,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          r_state;
  logic [BW-1:0]   r_baud;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift;
  logic            r_tx;
  logic            r_busy;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [7:0]      r_mem [FIFO_DEPTH];

  state_t          w_state_next;
  logic [BW-1:0]   w_baud_next;
  logic [2:0]      w_bit_next;
  logic [7:0]      w_shift_next;
  logic            w_tx_next;
  logic [CW-1:0]   w_count_next;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_baud_done;
  logic            w_unused_hi;

  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  assign w_push      = mmio_wea && !w_full;
  assign w_baud_done = (r_baud == '0);
  assign w_unused_hi = ^mmio_dat[31:8];

  assign mmio_read  = !w_full;
  assign tx         = r_tx;
  assign tx_busy    = r_busy;
  assign fifo_count = r_count;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit_idx;
    w_shift_next = r_shift;
    w_pop        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_baud_next  = BAUD_LOAD;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_next = S_DATA;
          w_bit_next   = '0;
          w_baud_next  = BAUD_LOAD;
        end else begin
          w_baud_next  = r_baud - BW'(1);
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_next = BAUD_LOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_shift_next = {1'b0, r_shift[7:1]};
            w_bit_next   = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_next = r_baud - BW'(1);
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_baud_next  = BAUD_LOAD;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud - BW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // The line level is registered from the next state, so tx never glitches.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_count   <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_busy    <= (w_state_next != S_IDLE) || (w_count_next != '0);
      r_count   <= w_count_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // NOTE: the storage array has no reset; the pointers and count decide which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mmio_dat[7:0];
  end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Bench for uart_mmio_tx: directed writes push expected bytes into a queue; a
// line monitor decodes each tx frame and compares it against the queue head.
`timescale 1ns/1ps
module tb_uart_mmio_tx;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          Rst = 1'b0;
  logic          mmio_wea = 1'b0;
  logic [31:0]   mmio_dat = '0;
  logic          mmio_read;
  logic          tx;
  logic          tx_busy;
  logic [CW-1:0] fifo_count;

  int        cyc = 0;
  int        n_checks = 0;
  int        n_errors = 0;
  int        frames_done = 0;
  bit        in_frame = 1'b0;
  logic [7:0] exp_q[$];
  int        start_q[$];

  uart_mmio_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .mmio_wea   (mmio_wea),
    .mmio_dat   (mmio_dat),
    .mmio_read  (mmio_read),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int get_start(input int idx);
    if (idx < start_q.size()) return start_q[idx];
    return -1;
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [31:0] d);
    mmio_wea = 1'b1;
    mmio_dat = d;
    next_cyc();
    mmio_wea = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cyc();
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((tx_busy !== 1'b0 || exp_q.size() != 0 || in_frame) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < max_cyc), 1);
    next_cyc();
  endtask

  // Line monitor: decodes frames, checks every sample of each bit is stable.
  initial begin : monitor
    logic [7:0] got;
    logic       lvl;
    logic       stop_lvl;
    int         bad;
    bit         abort;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (Rst === 1'b1 && tx === 1'b0) begin
        in_frame = 1'b1;
        start_q.push_back(cyc);
        got = '0; bad = 0; abort = 1'b0; stop_lvl = 1'bx; lvl = 1'b0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int s = 0; s < CPB && !abort; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (Rst !== 1'b1) abort = 1'b1;
            else if (s == 0) lvl = tx;
            else if (tx !== lvl) bad++;
          end
          if (!abort) begin
            if (b >= 1 && b <= 8) got[b-1] = lvl;
            if (b == 9) stop_lvl = lvl;
          end
        end
        in_frame = 1'b0;
        if (!abort) begin
          frames_done++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: got byte %0h, expected no frame", got);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'h0, got}, {24'h0, e});
          end
          check("frame_bit_timing", bad, 0);
          check("stop_bit", {31'h0, stop_lvl}, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k, ns, nf, hi, low;
    int exp_cnt [6] = '{0, 1, 1, 2, 3, 4};
    int exp_rd  [6] = '{1, 1, 1, 1, 1, 0};

    // 1. Reset
    Rst = 1'b0;
    repeat (3) next_cyc();
    Rst = 1'b1;
    next_cyc();
    @(negedge clk);
    check("reset_tx", {31'h0, tx}, 1);
    check("reset_mmio_read", {31'h0, mmio_read}, 1);
    check("reset_tx_busy", {31'h0, tx_busy}, 0);
    check("reset_fifo_count", fifo_count, 0);
    next_cyc();

    // 2. Single byte, upper data bits ignored, tx falls 2 cycles after strobe
    ns = start_q.size();
    k  = cyc;
    exp_q.push_back(8'hA5);
    write_byte(32'hFFFF_FFA5);
    wait_drain(300);
    check("single_frames", start_q.size(), ns + 1);
    check("single_latency", get_start(ns), k + 2);

    // 3. Back-to-back frames, tx_busy high for exactly 160 cycles
    ns = start_q.size();
    k  = cyc;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    write_byte(32'h1234_5600);
    write_byte(32'hABCD_EFFF);
    @(negedge clk);
    hi = 0;
    for (int i = 0; i < 160; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_busy === 1'b1) hi++;
    end
    check("b2b_busy_cycles", hi, 160);
    @(negedge clk);
    check("b2b_busy_drop", {31'h0, tx_busy}, 0);
    next_cyc();
    wait_drain(300);
    check("b2b_first_start", get_start(ns), k + 2);
    check("b2b_no_gap", get_start(ns + 1) - get_start(ns), 10 * CPB);

    // 4. Fill to full, sixth byte dropped
    ns = start_q.size();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 6; i++) begin
      mmio_wea = 1'b1;
      mmio_dat = 32'(i + 1);
      @(negedge clk);
      check("full_count", fifo_count, exp_cnt[i]);
      check("full_mmio_read", {31'h0, mmio_read}, exp_rd[i]);
      next_cyc();
    end
    mmio_wea = 1'b0;
    @(negedge clk);
    check("full_count_after_drop", fifo_count, 4);
    next_cyc();
    wait_drain(600);
    check("full_frames", start_q.size(), ns + 5);

    // 5. Reset during data bit 3 with two bytes queued
    k = cyc;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    write_byte(32'h3C);
    write_byte(32'h11);
    write_byte(32'h22);
    wait_until(k + 37);
    @(negedge clk);
    check("midrst_queued", fifo_count, 2);
    next_cyc();
    Rst = 1'b0;
    next_cyc();
    Rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tx", {31'h0, tx}, 1);
    check("midrst_count", fifo_count, 0);
    check("midrst_busy", {31'h0, tx_busy}, 0);
    check("midrst_mmio_read", {31'h0, mmio_read}, 1);
    nf  = frames_done;
    ns  = start_q.size();
    low = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    check("midrst_line_idle", low, 0);
    check("midrst_no_new_start", start_q.size(), ns);
    check("midrst_no_frames", frames_done, nf);
    next_cyc();

    // 6. Push and pop on the same cycle as the end of a stop bit
    ns = start_q.size();
    k  = cyc;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h81);
    write_byte(32'h5A);
    write_byte(32'hC3);
    wait_until(k + 81);
    mmio_wea = 1'b1;
    mmio_dat = 32'h81;
    next_cyc();
    mmio_wea = 1'b0;
    @(negedge clk);
    check("simul_count", fifo_count, 1);
    check("simul_tx_start", {31'h0, tx}, 0);
    next_cyc();
    wait_drain(500);
    check("simul_second_start", get_start(ns + 1), k + 82);
    check("simul_third_start", get_start(ns + 2), k + 162);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_mmio_tx.md
Name: uart_mmio_tx

Overview:
- MMIO-driven UART transmitter: the transmit-side counterpart of the UART instruction programmer.
- Memory stage writes a byte via mmio_wea/mmio_dat. The byte is queued in a small FIFO and serialised on tx as 8N1, LSB first.
- mmio_read is returned to the memory stage as the "write accepted / space available" status.
- Sits beside the core inside the top-level, clocked from clk.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range 4 to 65535.
FIFO_DEPTH, 16, byte entries in the transmit FIFO; power of two, 2 to 256.

Ports:
clk  input  1  system clock; all logic on the rising edge.
Rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising edge of clk.
mmio_wea  input  1  one-cycle write strobe from the memory stage.
mmio_dat  input  32  write data; only [7:0] is transmitted, [31:8] ignored.
mmio_read  output  1  1 = FIFO not full, so a write this cycle is accepted.
tx  output  1  UART serial line; idle high.
tx_busy  output  1  1 while a frame is on the line or the FIFO is non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte currently being shifted.

Behaviour:
- Reset (Rst=0 at an edge):
  - tx=1, mmio_read=1, tx_busy=0, fifo_count=0.
  - FSM goes to IDLE; pointers and counters are cleared.
  - Reset mid-frame aborts the frame immediately: tx returns high the next cycle and queued bytes are discarded.
- FIFO:
  - Write occurs when mmio_wea=1 and fifo_count<FIFO_DEPTH. mmio_read is the combinational inverse of full.
  - Write while full: byte dropped silently. No pointer or count change, no overflow flag.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - fifo_count is registered and updated the cycle after a push or pop.
  - Simultaneous push and pop in one cycle: count unchanged, both take effect.
- Serialiser FSM, states IDLE, START, DATA, STOP:
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - Pop latency: a byte written into an empty FIFO while idle produces tx falling edge 2 cycles after the mmio_wea cycle (1 cycle FIFO write, 1 cycle pop/start).
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no extra idle bit); else go to IDLE.
- Bit timing:
  - Baud counter is a down-counter of width $clog2(CLKS_PER_BIT).
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - One frame is exactly 10*CLKS_PER_BIT cycles.
- tx is driven from a register (glitch-free); it changes only on clk edges.
- tx_busy = (state!=IDLE) or (fifo_count!=0), registered.
- Writes during an active frame only enqueue; they never disturb the frame in progress.

Test Plan:
1. Reset: hold Rst=0 for 3 cycles, then release -> tx=1, mmio_read=1, tx_busy=0, fifo_count=0.
2. Single byte:
   - Stimulus: CLKS_PER_BIT=8, write mmio_dat=32'hFFFF_FFA5 while idle.
   - Required: tx falls 2 cycles after the strobe. Frame is 0,1,0,1,0,0,1,0,1,1 (start, bits A5 LSB-first, stop), each level held exactly 8 cycles; 80 cycles total. Bits [31:8] have no effect.
3. Back-to-back: write 8'h00 then 8'h FF on consecutive cycles -> two frames with no idle gap between them; tx_busy stays 1 for 160 cycles, then drops.
4. Full/overflow:
   - Stimulus: FIFO_DEPTH=4; write 6 bytes (8'h01..8'h06) on consecutive cycles while idle.
   - Required: first byte popped immediately; fifo_count peaks at 4; mmio_read=0 while full; exactly one of 05/06 is dropped (06). Line carries 01,02,03,04,05.
5. Reset mid-frame: pulse Rst=0 during the DATA bit 3 of byte 8'h3C with 2 bytes queued -> tx=1 the cycle after reset, fifo_count=0, no further frames.
6. Simultaneous push/pop: write a byte on the exact cycle STOP ends with 1 byte queued -> fifo_count stays 1, next frame starts in the same cycle, and the new byte follows it.
